// File: rtl/ray_generator.sv
// Primary-ray source: walks a WIDTH x HEIGHT frame in raster order and streams
// one Q16.16 ray (origin, direction, squared length) per pixel over valid/ready.
module ray_generator #(
    parameter int                 WIDTH  = 320,
    parameter int                 HEIGHT = 240,
    parameter logic signed [31:0] STEP   = 32'h0000_0222,
    parameter logic signed [31:0] FOCAL  = 32'h0001_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [31:0]               cam_x,
    input  logic [31:0]               cam_y,
    input  logic [31:0]               cam_z,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [31:0]               ro_x,
    output logic [31:0]               ro_y,
    output logic [31:0]               ro_z,
    output logic [31:0]               rd_x,
    output logic [31:0]               rd_y,
    output logic [31:0]               rd_z,
    output logic [31:0]               len2,
    output logic [$clog2(WIDTH)-1:0]  pix_x,
    output logic [$clog2(HEIGHT)-1:0] pix_y,
    output logic                      last
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic signed [31:0] HALF_W = WIDTH / 2;
    localparam logic signed [31:0] HALF_H = HEIGHT / 2;
    localparam logic signed [31:0] U0     = -(HALF_W * STEP);
    localparam logic signed [31:0] V0     = HALF_H * STEP;
    localparam logic signed [63:0] FSQ    = FOCAL * FOCAL;
    localparam logic [31:0]        F2     = FSQ[47:16];

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [XW-1:0]      x;
        logic [YW-1:0]      y;
        logic signed [31:0] u;
        logic signed [31:0] v;
    } gen_t;

    state_t            state, state_nx;
    gen_t              s1;
    logic [1:0]        vld_pipe;   // [0] = generator stage, [1] = output register
    logic              acc_start, ld2, hs, fin, s1_end_x, s1_end_y;
    logic signed [63:0] usq, vsq;
    logic [31:0]       len2_nx;
    logic              unused_sq;

    assign m_valid   = vld_pipe[1];
    assign busy      = (state == RUN);
    assign acc_start = (state == IDLE) & start;
    assign ld2       = vld_pipe[0] & (~vld_pipe[1] | m_ready);
    assign hs        = vld_pipe[1] & m_ready;
    assign fin       = (state == RUN) & hs & last;
    assign s1_end_x  = (s1.x == XW'(WIDTH - 1));
    assign s1_end_y  = (s1.y == YW'(HEIGHT - 1));

    // Squares are full Q32.32; keep the Q16.16 window and wrap on the sum.
    assign usq       = s1.u * s1.u;
    assign vsq       = s1.v * s1.v;
    assign len2_nx   = usq[47:16] + vsq[47:16] + F2;
    assign unused_sq = ^{usq[63:48], usq[15:0], vsq[63:48], vsq[15:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (fin)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe   <= '0;
            s1         <= '0;
            ro_x       <= '0;
            ro_y       <= '0;
            ro_z       <= '0;
            rd_x       <= '0;
            rd_y       <= '0;
            rd_z       <= '0;
            len2       <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            last       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= fin;
            if (acc_start) begin
                ro_x        <= cam_x;
                ro_y        <= cam_y;
                ro_z        <= cam_z;
                s1.x        <= '0;
                s1.y        <= '0;
                s1.u        <= U0;
                s1.v        <= V0;
                vld_pipe[0] <= 1'b1;
            end else if (ld2) begin
                // Incremental stepping keeps multipliers off the u/v path.
                if (!s1_end_x) begin
                    s1.x <= s1.x + 1'b1;
                    s1.u <= s1.u + STEP;
                end else if (!s1_end_y) begin
                    s1.x <= '0;
                    s1.u <= U0;
                    s1.y <= s1.y + 1'b1;
                    s1.v <= s1.v - STEP;
                end else begin
                    vld_pipe[0] <= 1'b0;
                end
            end

            if (ld2) begin
                rd_x        <= s1.u;
                rd_y        <= s1.v;
                rd_z        <= FOCAL;
                len2        <= len2_nx;
                pix_x       <= s1.x;
                pix_y       <= s1.y;
                last        <= s1_end_x & s1_end_y;
                vld_pipe[1] <= 1'b1;
            end else if (hs) begin
                vld_pipe[1] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ray_generator.sv
// Directed bench for ray_generator on a 4x2 frame with STEP = 0.5.
module tb_ray_generator;
    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst, start, m_ready;
    logic [31:0] cam_x, cam_y, cam_z;
    logic        busy, frame_done, m_valid, last;
    logic [31:0] ro_x, ro_y, ro_z, rd_x, rd_y, rd_z, len2;
    logic [1:0]  pix_x;
    logic [0:0]  pix_y;

    int n_chk  = 0;
    int n_fail = 0;

    // Hand-derived: u = -1.0 + 0.5*x, v = 0.5 - 0.5*y, len2 = u^2 + v^2 + 1.0
    logic [31:0] e_rdx [N] = '{32'hFFFF0000, 32'hFFFF8000, 32'h00000000, 32'h00008000,
                               32'hFFFF0000, 32'hFFFF8000, 32'h00000000, 32'h00008000};
    logic [31:0] e_rdy [N] = '{32'h00008000, 32'h00008000, 32'h00008000, 32'h00008000,
                               32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    logic [31:0] e_len [N] = '{32'h00024000, 32'h00018000, 32'h00014000, 32'h00018000,
                               32'h00020000, 32'h00014000, 32'h00010000, 32'h00014000};

    always #5 clk = ~clk;

    ray_generator #(.WIDTH(W), .HEIGHT(H), .STEP(32'h0000_8000), .FOCAL(32'h0001_0000)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cam_x(cam_x), .cam_y(cam_y), .cam_z(cam_z),
        .busy(busy), .frame_done(frame_done),
        .m_valid(m_valid), .m_ready(m_ready),
        .ro_x(ro_x), .ro_y(ro_y), .ro_z(ro_z),
        .rd_x(rd_x), .rd_y(rd_y), .rd_z(rd_z),
        .len2(len2), .pix_x(pix_x), .pix_y(pix_y), .last(last)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered in the cycle after the accepted start; returns in the frame_done cycle.
    task automatic run_frame(input bit rnd, input bit poke,
                             input logic [31:0] ex, input logic [31:0] ey, input logic [31:0] ez);
        int          idx;
        int          c;
        bit          stall;
        bit          poked;
        logic [31:0] s_rdx, s_rdy, s_len;
        logic [2:0]  s_pix;
        logic        s_last;
        idx = 0; c = 1; stall = 0; poked = 0;
        s_rdx = '0; s_rdy = '0; s_len = '0; s_pix = '0; s_last = 0;
        while (idx < N && c < 300) begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke && idx == 3 && !poked) begin
                start = 1'b1;
                cam_x = 32'h00050000; cam_y = 32'h00060000; cam_z = 32'h00070000;
                poked = 1;
            end else begin
                start = 1'b0;
            end
            chk("busy_in_frame", 64'(busy), 64'(1));
            chk("done_low_in_frame", 64'(frame_done), 64'(0));
            if (!rnd) chk("valid_timing", 64'(m_valid), 64'(c >= 2));
            if (stall) begin
                chk("hold_valid", 64'(m_valid), 64'(1));
                chk("hold_rd_x", 64'(rd_x), 64'(s_rdx));
                chk("hold_rd_y", 64'(rd_y), 64'(s_rdy));
                chk("hold_len2", 64'(len2), 64'(s_len));
                chk("hold_pix", 64'({pix_y, pix_x}), 64'(s_pix));
                chk("hold_last", 64'(last), 64'(s_last));
            end
            if (m_valid && m_ready) begin
                chk("rd_x", 64'(rd_x), 64'(e_rdx[idx]));
                chk("rd_y", 64'(rd_y), 64'(e_rdy[idx]));
                chk("rd_z", 64'(rd_z), 64'(32'h00010000));
                chk("len2", 64'(len2), 64'(e_len[idx]));
                chk("pix_x", 64'(pix_x), 64'(idx % W));
                chk("pix_y", 64'(pix_y), 64'(idx / W));
                chk("last", 64'(last), 64'(idx == N - 1));
                chk("ro_x", 64'(ro_x), 64'(ex));
                chk("ro_y", 64'(ro_y), 64'(ey));
                chk("ro_z", 64'(ro_z), 64'(ez));
                idx++;
            end
            stall  = m_valid && !m_ready;
            s_rdx  = rd_x; s_rdy = rd_y; s_len = len2;
            s_pix  = {pix_y, pix_x}; s_last = last;
            tick;
            c++;
        end
        start = 1'b0;
        chk("ray_count", 64'(idx), 64'(N));
        chk("done_pulse", 64'(frame_done), 64'(1));
        chk("done_valid", 64'(m_valid), 64'(0));
        chk("done_busy", 64'(busy), 64'(0));
        if (!rnd) chk("done_cycle", 64'(c), 64'(10));
        m_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; m_ready = 1'b0;
        cam_x = '0; cam_y = '0; cam_z = '0;
        tick; tick;
        chk("rst_valid", 64'(m_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(frame_done), 64'(0));
        chk("rst_last", 64'(last), 64'(0));
        chk("rst_ro", 64'({ro_x, ro_y} | 64'(ro_z)), 64'(0));
        chk("rst_rd", 64'({rd_x, rd_y} | 64'(rd_z)), 64'(0));
        chk("rst_len2", 64'(len2), 64'(0));
        chk("rst_pix", 64'({pix_y, pix_x}), 64'(0));

        start = 1'b1;
        tick;
        chk("start_in_rst_busy", 64'(busy), 64'(0));
        chk("start_in_rst_valid", 64'(m_valid), 64'(0));
        rst = 1'b0; start = 1'b0;
        tick;
        chk("post_rst_busy", 64'(busy), 64'(0));

        // Full frame, m_ready held high
        cam_x = 32'h00010000; cam_y = 32'h00020000; cam_z = 32'hFFFD0000;
        m_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        run_frame(0, 0, 32'h00010000, 32'h00020000, 32'hFFFD0000);
        tick;
        chk("done_one_cycle", 64'(frame_done), 64'(0));

        // Random backpressure
        start = 1'b1;
        tick;
        start = 1'b0;
        run_frame(1, 0, 32'h00010000, 32'h00020000, 32'hFFFD0000);
        tick;

        // start pulsed mid-frame with a different camera is ignored
        start = 1'b1;
        tick;
        start = 1'b0;
        run_frame(0, 1, 32'h00010000, 32'h00020000, 32'hFFFD0000);
        cam_x = 32'h00010000; cam_y = 32'h00020000; cam_z = 32'hFFFD0000;
        tick;

        // Reset after the third handshake
        start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick; tick;
        chk("mid_pix_x", 64'(pix_x), 64'(3));
        rst = 1'b1;
        tick;
        chk("midrst_valid", 64'(m_valid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_len2", 64'(len2), 64'(0));
        chk("midrst_pix", 64'({pix_y, pix_x}), 64'(0));
        rst = 1'b0;
        tick;
        chk("midrst_stays_idle", 64'({busy, m_valid}), 64'(0));
        start = 1'b1;
        tick;
        start = 1'b0;
        run_frame(0, 0, 32'h00010000, 32'h00020000, 32'hFFFD0000);

        // Back-to-back: start in the frame_done cycle
        start = 1'b1;
        tick;
        start = 1'b0;
        run_frame(0, 0, 32'h00010000, 32'h00020000, 32'hFFFD0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
